// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores to a 16-bit asynchronous SRAM.
// Each word access is two halfword phases (LO, then HI), and each phase lasts WAIT_CYCLES+1 clocks.
module sram_controller #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0] waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        read_data_q, read_data_d;

  logic [31:0] addr_off;
  logic        phase_hi;
  logic        cnt_last;
  logic        unused_addr_bits;

  assign addr_off = address - BASE_ADDR;
  // Bits above the SRAM word range are dropped, so out-of-range addresses wrap.
  assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};
  assign phase_hi  = (state_q == HI);
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign ready     = ~(wr_en | rd_en) | (state_q == DONE);
  assign read_data = read_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;

    case (state_q)
      IDLE: begin
        if (wr_en | rd_en) begin
          op_wr_d = wr_en;
          waddr_d = addr_off[SRAM_AW:2];
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = LO;
        end
      end
      LO, HI: begin
        sram_addr = {waddr_q, phase_hi};
        if (op_wr_q) begin
          sram_dq_out = phase_hi ? wdata_q[31:16] : wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          // Strobe releases one cycle early so address/data are stable at the we_n rising edge.
          sram_we_n   = cnt_last;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = phase_hi ? DONE : HI;
          if (!op_wr_q) begin
            if (phase_hi) read_data_d[31:16] = sram_dq_in;
            else          read_data_d[15:0]  = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (WAIT_CYCLES=1 and 3), each with a behavioural SRAM.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance with WAIT_CYCLES=1 ----------------
  logic        rst1, wr_en1, rd_en1, ready1;
  logic [31:0] address1, write_data1, read_data1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1, sram_oe_n1;
  logic [15:0] mem1 [0:255];

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr_en1), .rd_en(rd_en1),
    .address(address1), .write_data(write_data1), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
    .sram_dq_in(sram_dq_in1), .sram_dq_oe(sram_dq_oe1),
    .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1)
  );

  always @(negedge clk) begin
    if (rst1) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 16'h0000;
    end else if (sram_dq_oe1 && !sram_we_n1) begin
      mem1[sram_addr1[7:0]] <= sram_dq_out1;
    end
  end
  always_comb sram_dq_in1 = mem1[sram_addr1[7:0]];

  // ---------------- instance with WAIT_CYCLES=3 ----------------
  logic        rst3, wr_en3, rd_en3, ready3;
  logic [31:0] address3, write_data3, read_data3;
  logic [17:0] sram_addr3;
  logic [15:0] sram_dq_out3, sram_dq_in3;
  logic        sram_dq_oe3, sram_we_n3, sram_oe_n3;
  logic [15:0] mem3 [0:15];

  sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut3 (
    .clk(clk), .rst(rst3), .wr_en(wr_en3), .rd_en(rd_en3),
    .address(address3), .write_data(write_data3), .read_data(read_data3),
    .ready(ready3), .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3),
    .sram_dq_in(sram_dq_in3), .sram_dq_oe(sram_dq_oe3),
    .sram_we_n(sram_we_n3), .sram_oe_n(sram_oe_n3)
  );

  always @(negedge clk) begin
    if (rst3) begin
      for (int i = 0; i < 16; i++) mem3[i] <= 16'h0000;
    end else if (sram_dq_oe3 && !sram_we_n3) begin
      mem3[sram_addr3[3:0]] <= sram_dq_out3;
    end
  end
  always_comb sram_dq_in3 = mem3[sram_addr3[3:0]];

  // One access on dut1: counts cycles with ready low and with we_n low, then drops the request after DONE.
  task automatic access1(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, output int lows, output int we_lows);
    @(posedge clk); #1;
    wr_en1 = wr; rd_en1 = rd; address1 = a; write_data1 = d;
    lows = 0; we_lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready1) break;
      lows++;
      if (!sram_we_n1) we_lows++;
    end
    @(posedge clk); #1;
    wr_en1 = 1'b0; rd_en1 = 1'b0;
    $display("[TB] dut1 wr=%0b rd=%0b addr=%0d data=%h ready_low=%0d we_low=%0d read_data=%h",
             wr, rd, a, d, lows, we_lows, read_data1);
  endtask

  task automatic access3(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, output int lows, output int we_lows);
    @(posedge clk); #1;
    wr_en3 = wr; rd_en3 = rd; address3 = a; write_data3 = d;
    lows = 0; we_lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready3) break;
      lows++;
      if (!sram_we_n3) we_lows++;
    end
    @(posedge clk); #1;
    wr_en3 = 1'b0; rd_en3 = 1'b0;
    $display("[TB] dut3 wr=%0b rd=%0b addr=%0d data=%h ready_low=%0d we_low=%0d read_data=%h",
             wr, rd, a, d, lows, we_lows, read_data3);
  endtask

  task automatic test_reset();
    rst1 = 1'b1; wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = '0; write_data1 = '0;
    rst3 = 1'b1; wr_en3 = 1'b0; rd_en3 = 1'b0; address3 = '0; write_data3 = '0;
    repeat (3) @(posedge clk);
    #1; rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    $display("[TB] reset: ready=%0b we_n=%0b oe_n=%0b dq_oe=%0b addr=%h dq_out=%h read_data=%h",
             ready1, sram_we_n1, sram_oe_n1, sram_dq_oe1, sram_addr1, sram_dq_out1, read_data1);
    tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready1); end
    tests++; if ({sram_we_n1, sram_oe_n1, sram_dq_oe1} !== 3'b110) begin
      fails++; $display("FAIL reset_strobes got %b want 110", {sram_we_n1, sram_oe_n1, sram_dq_oe1}); end
    tests++; if (sram_addr1 !== 18'd0 || sram_dq_out1 !== 16'h0) begin
      fails++; $display("FAIL reset_bus got addr=%h dq=%h want 0/0", sram_addr1, sram_dq_out1); end
    tests++; if (read_data1 !== 32'h0) begin
      fails++; $display("FAIL reset_read_data got %h want 00000000", read_data1); end
  endtask

  task automatic test_write_read();
    int lows, we_lows;
    access1(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lows, we_lows);
    tests++; if (lows !== 5) begin fails++; $display("FAIL wr_latency got %0d want 5", lows); end
    tests++; if (we_lows !== 2) begin fails++; $display("FAIL wr_we_pulses got %0d want 2", we_lows); end
    tests++; if (mem1[0] !== 16'hBEEF || mem1[1] !== 16'hDEAD) begin
      fails++; $display("FAIL wr_halves got %h/%h want BEEF/DEAD", mem1[0], mem1[1]); end
    access1(1'b0, 1'b1, 32'd1024, 32'h0, lows, we_lows);
    tests++; if (lows !== 5) begin fails++; $display("FAIL rd_latency got %0d want 5", lows); end
    tests++; if (read_data1 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_data got %h want DEADBEEF", read_data1); end
  endtask

  task automatic test_address_map();
    int lows, we_lows;
    access1(1'b1, 1'b0, 32'd1028, 32'hA5A55A5A, lows, we_lows);
    tests++; if (mem1[2] !== 16'h5A5A || mem1[3] !== 16'hA5A5) begin
      fails++; $display("FAIL map_halves got %h/%h want 5A5A/A5A5", mem1[2], mem1[3]); end
    tests++; if (mem1[0] !== 16'hBEEF || mem1[1] !== 16'hDEAD) begin
      fails++; $display("FAIL map_neighbour got %h/%h want BEEF/DEAD", mem1[0], mem1[1]); end
    access1(1'b0, 1'b1, 32'd1028, 32'h0, lows, we_lows);
    tests++; if (read_data1 !== 32'hA5A55A5A) begin
      fails++; $display("FAIL map_read_1028 got %h want A5A55A5A", read_data1); end
    access1(1'b0, 1'b1, 32'd1024, 32'h0, lows, we_lows);
    tests++; if (read_data1 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL map_read_1024 got %h want DEADBEEF", read_data1); end
  endtask

  task automatic test_both_requests();
    int lows, we_lows;
    access1(1'b1, 1'b1, 32'd1032, 32'h12345678, lows, we_lows);
    tests++; if (we_lows !== 2) begin fails++; $display("FAIL both_we_pulses got %0d want 2", we_lows); end
    tests++; if (mem1[4] !== 16'h5678 || mem1[5] !== 16'h1234) begin
      fails++; $display("FAIL both_halves got %h/%h want 5678/1234", mem1[4], mem1[5]); end
    tests++; if (read_data1 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL both_read_data got %h want DEADBEEF", read_data1); end
  endtask

  task automatic test_request_drop();
    @(posedge clk); #1;
    rd_en1 = 1'b1; address1 = 32'd1032;
    @(posedge clk); #1;
    rd_en1 = 1'b0; address1 = 32'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("[TB] dropped read addr=1032 read_data=%h", read_data1);
    tests++; if (read_data1 !== 32'h12345678) begin
      fails++; $display("FAIL drop_read_data got %h want 12345678", read_data1); end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    wr_en1 = 1'b1; address1 = 32'd1040; write_data1 = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1; rst1 = 1'b1; wr_en1 = 1'b0;
    @(negedge clk);
    // Still in HI cnt0 of the write: reset is synchronous.
    tests++; if (sram_we_n1 !== 1'b0 || sram_dq_oe1 !== 1'b1 || sram_addr1 !== 18'd9) begin
      fails++; $display("FAIL mid_hi_phase got we_n=%b oe=%b addr=%0d want 0/1/9",
                        sram_we_n1, sram_dq_oe1, sram_addr1); end
    @(negedge clk);
    $display("[TB] reset mid-write: we_n=%0b dq_oe=%0b oe_n=%0b ready=%0b addr=%0d",
             sram_we_n1, sram_dq_oe1, sram_oe_n1, ready1, sram_addr1);
    tests++; if (sram_we_n1 !== 1'b1 || sram_dq_oe1 !== 1'b0 || sram_oe_n1 !== 1'b1) begin
      fails++; $display("FAIL mid_strobes got we_n=%b oe=%b oe_n=%b want 1/0/1",
                        sram_we_n1, sram_dq_oe1, sram_oe_n1); end
    tests++; if (ready1 !== 1'b1 || sram_addr1 !== 18'd0) begin
      fails++; $display("FAIL mid_idle got ready=%b addr=%0d want 1/0", ready1, sram_addr1); end
    #1; rst1 = 1'b0;
    @(negedge clk);
    tests++; if (sram_we_n1 !== 1'b1 || ready1 !== 1'b1) begin
      fails++; $display("FAIL mid_after got we_n=%b ready=%b want 1/1", sram_we_n1, ready1); end
  endtask

  task automatic test_wait_states();
    int lows, we_lows;
    access3(1'b1, 1'b0, 32'd1024, 32'h0BADC0DE, lows, we_lows);
    tests++; if (lows !== 9) begin fails++; $display("FAIL w3_wr_latency got %0d want 9", lows); end
    tests++; if (we_lows !== 6) begin fails++; $display("FAIL w3_we_low got %0d want 6", we_lows); end
    tests++; if (mem3[0] !== 16'hC0DE || mem3[1] !== 16'h0BAD) begin
      fails++; $display("FAIL w3_halves got %h/%h want C0DE/0BAD", mem3[0], mem3[1]); end
    access3(1'b0, 1'b1, 32'd1024, 32'h0, lows, we_lows);
    tests++; if (lows !== 9) begin fails++; $display("FAIL w3_rd_latency got %0d want 9", lows); end
    tests++; if (read_data3 !== 32'h0BADC0DE) begin
      fails++; $display("FAIL w3_rd_data got %h want 0BADC0DE", read_data3); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_address_map();
    test_both_requests();
    test_request_drop();
    test_reset_mid_access();
    test_wait_states();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
